// File: rtl/load_store_unit.sv
// load_store_unit: one RV32I load/store per op over a req/gnt/rvalid data-memory port.
module load_store_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_store_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [2:0]        funct3_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_n;
  logic we_q, err_q, accept, legal, mis, err;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [3:0] be_q, be;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wd_q, rd_q, wd, sh, ext;
  assign accept = req_valid_i && req_ready_o;
  assign legal  = is_store_i ? funct3_i < 3'd3 : (funct3_i != 3'd3 && funct3_i < 3'd6);
  assign mis    = (funct3_i[1:0] == 2'd1 && addr_i[0]) || (funct3_i[1:0] == 2'd2 && addr_i[1:0] != 2'd0);
  assign err    = !legal || mis;
  assign be     = funct3_i[1:0] == 2'd0 ? 4'b0001 << addr_i[1:0] :
                  funct3_i[1:0] == 2'd1 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd     = !is_store_i ? '0 :
                  funct3_i[1:0] == 2'd0 ? {4{wdata_i[7:0]}} :
                  funct3_i[1:0] == 2'd1 ? {2{wdata_i[15:0]}} : wdata_i;
  // Bring the addressed lane down to bit 0, then extend; f3[2] selects unsigned.
  assign sh     = mem_rdata_i >> {off_q, 3'b000};
  assign ext    = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
                  f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : sh;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (req_valid_i ? (err ? RESP : REQ) : IDLE) :
              state == REQ  ? (mem_gnt_i ? (we_q ? RESP : WAIT) : REQ) :
              state == WAIT ? (mem_rvalid_i ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      f3_q   <= '0;
      off_q  <= '0;
      be_q   <= '0;
      addr_q <= '0;
      wd_q   <= '0;
      rd_q   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q   <= is_store_i;
        err_q  <= err;
        f3_q   <= funct3_i;
        off_q  <= addr_i[1:0];
        be_q   <= err ? 4'b0000 : be;
        addr_q <= {addr_i[AWIDTH-1:2], 2'b00};
        wd_q   <= wd;
      end
      if (state == WAIT && mem_rvalid_i) rd_q <= ext;
    end
  end
  assign req_ready_o  = state == IDLE;
  assign mem_req_o    = state == REQ;
  assign resp_valid_o = state == RESP;
  assign resp_err_o   = resp_valid_o && err_q;
  assign rdata_o      = (resp_valid_o && !err_q && !we_q) ? rd_q : '0;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_be_o     = be_q;
  assign mem_wdata_o  = wd_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed ops with a response scoreboard checked by an independent monitor.
module tb_load_store_unit;
  logic clk = 0, reset = 1;
  logic req_valid_i = 0, is_store_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, mem_rdata_i = 0;
  logic [2:0] funct3_i = 0;
  logic req_ready_o, resp_valid_o, resp_err_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_be_o;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int cyc; logic err; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .is_store_i(is_store_i), .addr_i(addr_i), .wdata_i(wdata_i), .funct3_i(funct3_i),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid_o) begin
      if (sb.size() == 0) chk("unexpected_resp", {31'd0, resp_valid_o}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_err", {31'd0, resp_err_o}, {31'd0, e.err});
        chk("resp_rdata", rdata_o, e.data);
      end
    end
  end

  task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] w,
                       input logic [2:0] f, input int lat, input logic er, input logic [31:0] d);
    req_valid_i = 1; is_store_i = st; addr_i = a; wdata_i = w; funct3_i = f;
    sb.push_back('{cyc + lat, er, d});
    @(negedge clk);
    chk("ready_idle", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk); #1;
    req_valid_i = 0;
  endtask

  task automatic grant(input int dly, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input logic we);
    for (int i = 0; i <= dly; i++) begin
      mem_gnt_i = (i == dly);
      @(negedge clk);
      chk("mem_req", {31'd0, mem_req_o}, 32'd1);
      chk("mem_addr", mem_addr_o, a);
      chk("mem_be", {28'd0, mem_be_o}, {28'd0, b});
      chk("mem_wdata", mem_wdata_o, wd);
      chk("mem_we", {31'd0, mem_we_o}, {31'd0, we});
      chk("ready_busy", {31'd0, req_ready_o}, 32'd0);
      @(posedge clk); #1;
    end
    mem_gnt_i = 0;
    @(negedge clk);
    chk("req_drop", {31'd0, mem_req_o}, 32'd0);
  endtask

  task automatic rvalid(input int dly, input logic [31:0] d);
    for (int i = 0; i <= dly; i++) begin
      mem_rvalid_i = (i == dly); mem_rdata_i = d;
      @(posedge clk); #1;
    end
    mem_rvalid_i = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (req_ready_o) break;
      n++;
    end
    chk("idle_timeout", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_resp", {30'd0, resp_valid_o, resp_err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_memctl", {30'd0, mem_req_o, mem_we_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    // LW aligned
    issue(0, 32'h100, 0, 3'b010, 3, 0, 32'hDEADBEEF);
    grant(0, 32'h100, 4'hF, 0, 0);
    rvalid(0, 32'hDEADBEEF);
    wait_idle();
    // LB / LBU top lane, rvalid delayed by one on LBU
    issue(0, 32'h103, 0, 3'b000, 3, 0, 32'hFFFFFF80);
    grant(0, 32'h100, 4'b1000, 0, 0);
    rvalid(0, 32'h80FF1234);
    wait_idle();
    issue(0, 32'h103, 0, 3'b100, 4, 0, 32'h00000080);
    grant(0, 32'h100, 4'b1000, 0, 0);
    rvalid(1, 32'h80FF1234);
    wait_idle();
    // SH upper half with grant held off 3 cycles
    issue(1, 32'h202, 32'h0000ABCD, 3'b001, 5, 0, 0);
    grant(3, 32'h200, 4'b1100, 32'hABCDABCD, 1);
    wait_idle();
    // Error ops: misaligned LW, illegal load code, misaligned LH, illegal store code
    issue(0, 32'h101, 0, 3'b010, 1, 1, 0);
    @(negedge clk); chk("err_noreq_lw", {31'd0, mem_req_o}, 32'd0);
    wait_idle();
    issue(0, 32'h100, 0, 3'b011, 1, 1, 0);
    @(negedge clk); chk("err_noreq_f3", {31'd0, mem_req_o}, 32'd0);
    wait_idle();
    issue(0, 32'h101, 0, 3'b001, 1, 1, 0);
    @(negedge clk); chk("err_noreq_lh", {31'd0, mem_req_o}, 32'd0);
    wait_idle();
    issue(1, 32'h100, 32'h1, 3'b100, 1, 1, 0);
    @(negedge clk); chk("err_noreq_st", {31'd0, mem_req_o}, 32'd0);
    wait_idle();
    // Reset while waiting for read data; late rvalid must be ignored
    issue(0, 32'h104, 0, 3'b010, 3, 0, 0);
    grant(0, 32'h104, 4'hF, 0, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("abort_noreq", {31'd0, mem_req_o}, 32'd0);
    chk("abort_ready", {31'd0, req_ready_o}, 32'd1);
    mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid_i = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_noresp", {31'd0, resp_valid_o}, 32'd0);
    end
    @(posedge clk); #1;
    issue(1, 32'h3, 32'h5A, 3'b000, 2, 0, 0);
    grant(0, 32'h0, 4'b1000, 32'h5A5A5A5A, 1);
    wait_idle();
    // SW then LHU back-to-back
    issue(1, 32'h10, 32'h12345678, 3'b010, 2, 0, 0);
    grant(0, 32'h10, 4'hF, 32'h12345678, 1);
    chk("resp_ready_low", {31'd0, req_ready_o}, 32'd0);
    @(posedge clk); #1;
    issue(0, 32'h2, 0, 3'b101, 3, 0, 32'h0000F00D);
    grant(0, 32'h0, 4'b1100, 0, 0);
    rvalid(0, 32'hF00D0000);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
